// File: rtl/sr_flag_arbiter.sv
// sr_flag_arbiter: a round-robin arbiter in front of a shared bank of SR flags.
// Each cycle at most one requester wins. The winner's set/clear masks are then
// applied to the bank. A bit with both set and clear requested keeps its value,
// and the command is reported as a conflict.
module sr_flag_arbiter #(
    parameter int NREQ  = 4,
    parameter int NFLAG = 8,
    parameter int CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*NFLAG-1:0] set_mask,
    input  logic [NREQ*NFLAG-1:0] clr_mask,
    output logic [NREQ-1:0]       gnt,
    output logic [NFLAG-1:0]      q,
    output logic [NFLAG-1:0]      q_bar,
    output logic                  err,
    output logic [CNT_W-1:0]      err_cnt,
    output logic                  busy
);

    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PTR_W-1:0] ptr;
    logic [NREQ-1:0]  eligible;
    logic             found;
    logic [PTR_W-1:0] win;
    logic             hi_found;
    logic             lo_found;
    logic [PTR_W-1:0] hi_win;
    logic [PTR_W-1:0] lo_win;
    logic [NFLAG-1:0] s;
    logic [NFLAG-1:0] c;
    logic [NFLAG-1:0] q_next;
    logic             conflict;
    logic [NREQ-1:0]  gnt_next;
    logic [PTR_W-1:0] ptr_next;

    // A requester whose grant is currently showing cannot win again this cycle.
    assign eligible = req & ~gnt;
    assign busy     = |eligible;
    assign q_bar    = ~q;

    // Round-robin winner search, starting at ptr.
    // The wrapped search is done as two ascending scans: the first eligible
    // index at or above ptr, or failing that the first eligible index overall.
    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_win   = '0;
        lo_win   = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (eligible[i] && !lo_found) begin
                lo_found = 1'b1;
                lo_win   = PTR_W'(i);
            end
            if (eligible[i] && (PTR_W'(i) >= ptr) && !hi_found) begin
                hi_found = 1'b1;
                hi_win   = PTR_W'(i);
            end
        end
        found = hi_found | lo_found;
        win   = hi_found ? hi_win : lo_win;
    end

    // Winner's masks, the per-bit SR update, the next grant and the next pointer.
    always_comb begin
        s        = set_mask[int'(win)*NFLAG +: NFLAG];
        c        = clr_mask[int'(win)*NFLAG +: NFLAG];
        q_next   = (q | (s & ~c)) & ~(c & ~s);
        conflict = |(s & c);
        gnt_next = '0;
        if (found) begin
            gnt_next[win] = 1'b1;
        end
        ptr_next = (win == PTR_W'(NREQ - 1)) ? '0 : win + PTR_W'(1);
    end

    // Registered state: grant pulse, flag bank, pointer, conflict pulse and counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt     <= '0;
            q       <= '0;
            ptr     <= '0;
            err     <= 1'b0;
            err_cnt <= '0;
        end else begin
            gnt <= gnt_next;
            if (found) begin
                q   <= q_next;
                ptr <= ptr_next;
                err <= conflict;
                if (conflict && (err_cnt != '1)) begin
                    err_cnt <= err_cnt + CNT_W'(1);
                end
            end else begin
                err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sr_flag_arbiter.sv
// Directed testbench for sr_flag_arbiter. The main instance uses the default
// parameters. A second instance with a 2-bit counter exercises saturation.
module tb_sr_flag_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] set_mask;
    logic [31:0] clr_mask;
    logic [3:0]  gnt;
    logic [7:0]  q;
    logic [7:0]  q_bar;
    logic        err;
    logic [7:0]  err_cnt;
    logic        busy;

    logic [3:0]  req_s;
    logic [31:0] set_s;
    logic [31:0] clr_s;
    logic [3:0]  gnt_s;
    logic [7:0]  q_s;
    logic [7:0]  q_bar_s;
    logic        err_s;
    logic [1:0]  cnt_s;
    logic        busy_s;

    int errors;
    int checks;

    sr_flag_arbiter #(.NREQ(4), .NFLAG(8), .CNT_W(8)) u_dut (
        .clk(clk), .rst(rst), .req(req), .set_mask(set_mask), .clr_mask(clr_mask),
        .gnt(gnt), .q(q), .q_bar(q_bar), .err(err), .err_cnt(err_cnt), .busy(busy)
    );

    sr_flag_arbiter #(.NREQ(4), .NFLAG(8), .CNT_W(2)) u_sat (
        .clk(clk), .rst(rst), .req(req_s), .set_mask(set_s), .clr_mask(clr_s),
        .gnt(gnt_s), .q(q_s), .q_bar(q_bar_s), .err(err_s), .err_cnt(cnt_s), .busy(busy_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        req = '0; set_mask = '0; clr_mask = '0;
        req_s = '0; set_s = '0; clr_s = '0;
        do_reset();
        checks++; if (q !== 8'h00) begin errors++; $display("FAIL reset_q got=%h exp=00", q); end
        checks++; if (q_bar !== 8'hFF) begin errors++; $display("FAIL reset_q_bar got=%h exp=ff", q_bar); end
        checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt got=%b exp=0000", gnt); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", err); end
        checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL reset_err_cnt got=%0d exp=0", err_cnt); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    endtask

    task automatic test_basic();
        req = 4'b0001; set_mask[7:0] = 8'h0F; clr_mask[7:0] = 8'h00;
        #1;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy got=%b exp=1", busy); end
        tick();
        checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL basic_gnt1 got=%b exp=0001", gnt); end
        checks++; if (q !== 8'h0F) begin errors++; $display("FAIL basic_q1 got=%h exp=0f", q); end
        req = 4'b0000;
        tick();
        checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL basic_gnt_pulse got=%b exp=0000", gnt); end
        req = 4'b0001; set_mask[7:0] = 8'h00; clr_mask[7:0] = 8'h03;
        tick();
        checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL basic_gnt2 got=%b exp=0001", gnt); end
        checks++; if (q !== 8'h0C) begin errors++; $display("FAIL basic_q2 got=%h exp=0c", q); end
        checks++; if (q_bar !== 8'hF3) begin errors++; $display("FAIL basic_q_bar2 got=%h exp=f3", q_bar); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL basic_err got=%b exp=0", err); end
        req = 4'b0000; clr_mask = '0;
        tick();
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_seq [5];
        exp_seq[0] = 4'b0001; exp_seq[1] = 4'b0010; exp_seq[2] = 4'b0100;
        exp_seq[3] = 4'b1000; exp_seq[4] = 4'b0001;
        do_reset();
        set_mask = '0; clr_mask = '0; req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            tick();
            checks++;
            if (gnt !== exp_seq[k]) begin
                errors++; $display("FAIL rr_gnt[%0d] got=%b exp=%b", k, gnt, exp_seq[k]);
            end
        end
        checks++; if (q !== 8'h00) begin errors++; $display("FAIL rr_q got=%h exp=00", q); end
        req = 4'b0000;
        tick();
    endtask

    task automatic test_conflict();
        do_reset();
        req = 4'b0100; set_mask[23:16] = 8'h81; clr_mask[23:16] = 8'h80;
        tick();
        checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL conf_gnt got=%b exp=0100", gnt); end
        checks++; if (q !== 8'h01) begin errors++; $display("FAIL conf_q got=%h exp=01", q); end
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL conf_err got=%b exp=1", err); end
        checks++; if (err_cnt !== 8'd1) begin errors++; $display("FAIL conf_cnt got=%0d exp=1", err_cnt); end
        req = 4'b0000; set_mask = '0; clr_mask = '0;
        tick();
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL conf_err_pulse got=%b exp=0", err); end
        checks++; if (err_cnt !== 8'd1) begin errors++; $display("FAIL conf_cnt_hold got=%0d exp=1", err_cnt); end
    endtask

    // Continues from the conflict state: q=01, err_cnt=1, ptr=3.
    task automatic test_async_reset();
        req = 4'b0010; set_mask[15:8] = 8'hA5; clr_mask[15:8] = 8'h5A;
        tick();
        checks++; if (q !== 8'hA5) begin errors++; $display("FAIL ar_pre_q got=%h exp=a5", q); end
        checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL ar_pre_gnt got=%b exp=0010", gnt); end
        req = 4'b0000; set_mask = '0; clr_mask = '0;
        #2 rst = 1'b1;
        #1;
        checks++; if (q !== 8'h00) begin errors++; $display("FAIL ar_q got=%h exp=00", q); end
        checks++; if (q_bar !== 8'hFF) begin errors++; $display("FAIL ar_q_bar got=%h exp=ff", q_bar); end
        checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL ar_gnt got=%b exp=0000", gnt); end
        checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL ar_err_cnt got=%0d exp=0", err_cnt); end
        tick();
        rst = 1'b0;
    endtask

    task automatic test_saturation();
        logic [1:0] exp_cnt [5];
        exp_cnt[0] = 2'd1; exp_cnt[1] = 2'd2; exp_cnt[2] = 2'd3;
        exp_cnt[3] = 2'd3; exp_cnt[4] = 2'd3;
        do_reset();
        req_s = 4'b0001; set_s[7:0] = 8'h01; clr_s[7:0] = 8'h01;
        for (int k = 0; k < 5; k++) begin
            tick();
            checks++;
            if (err_s !== 1'b1 || gnt_s !== 4'b0001 || cnt_s !== exp_cnt[k]) begin
                errors++;
                $display("FAIL sat_grant[%0d] got err=%b gnt=%b cnt=%0d exp err=1 gnt=0001 cnt=%0d",
                         k, err_s, gnt_s, cnt_s, exp_cnt[k]);
            end
            tick();
            checks++;
            if (err_s !== 1'b0 || gnt_s !== 4'b0000) begin
                errors++; $display("FAIL sat_gap[%0d] got err=%b gnt=%b exp err=0 gnt=0000", k, err_s, gnt_s);
            end
        end
        checks++;
        if (q_s !== 8'h00 || q_bar_s !== 8'hFF) begin
            errors++; $display("FAIL sat_q got q=%h q_bar=%h exp q=00 q_bar=ff", q_s, q_bar_s);
        end
        req_s = 4'b0000; set_s = '0; clr_s = '0;
        #1;
        checks++; if (busy_s !== 1'b0) begin errors++; $display("FAIL sat_busy got=%b exp=0", busy_s); end
    endtask

    task automatic test_back_to_back();
        int grants;
        grants = 0;
        do_reset();
        req = 4'b0010; set_mask = '0; clr_mask = '0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (gnt[1] === 1'b1) grants++;
            checks++;
            if (gnt !== ((k % 2 == 0) ? 4'b0010 : 4'b0000)) begin
                errors++;
                $display("FAIL holdoff_gnt[%0d] got=%b exp=%b", k, gnt, (k % 2 == 0) ? 4'b0010 : 4'b0000);
            end
        end
        checks++; if (grants !== 3) begin errors++; $display("FAIL holdoff_count got=%0d exp=3", grants); end
        req = 4'b0000;
        tick();
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst = 1'b0;
        test_reset();
        test_basic();
        test_round_robin();
        test_conflict();
        test_async_reset();
        test_saturation();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sr_flag_arbiter.md
Name: sr_flag_arbiter

Overview:
- Shared bank of NFLAG set/reset flags (SR flip-flop semantics) written by NREQ independent requesters.
- Round-robin arbiter grants exactly one requester per cycle and applies that requester's set/clear masks to the bank.
- Set+clear conflicts never produce X: the conflicted bit holds its value, and the conflict is flagged and counted.
- Sits between control agents and the status-flag bank; flag outputs feed downstream logic directly.

Parameters:
- NREQ, 4, number of requesters (2..8)
- NFLAG, 8, number of SR flags in the bank (1..32)
- CNT_W, 8, width of saturating conflict counter

Ports:
- clk  input  1  system clock, all state on posedge
- rst  input  1  asynchronous, active-high reset
- req  input  NREQ  per-requester request; held high until its gnt seen
- set_mask  input  NREQ*NFLAG  requester i's set mask in bits [i*NFLAG +: NFLAG]
- clr_mask  input  NREQ*NFLAG  requester i's clear mask, same packing
- gnt  output  NREQ  registered one-hot grant pulse, one cycle wide
- q  output  NFLAG  flag values
- q_bar  output  NFLAG  always bitwise ~q
- err  output  1  registered one-cycle pulse: applied command had a set+clear conflict
- err_cnt  output  CNT_W  saturating count of conflicting commands applied
- busy  output  1  combinational OR of eligible requests this cycle

Behaviour:
- Reset (async, immediate): q=0, q_bar=all 1, gnt=0, err=0, err_cnt=0, round-robin pointer ptr=0. Pending requests are lost; requesters re-present after rst falls.
- Eligibility: requester i is eligible in a cycle iff req[i]=1 and gnt[i]=0 (the registered grant currently showing). This blocks a double grant while the requester drops req.
- Arbitration (combinational within cycle N):
  - Search eligible requesters starting at index ptr, ascending, wrapping from NREQ-1 to 0.
  - The first found is the winner W. If none is eligible, there is no winner.
- At the posedge ending cycle N, if a winner exists:
  - gnt <= onehot(W).
  - ptr <= (W+1) mod NREQ.
  - Per-bit update with s=set_mask[W], c=clr_mask[W]: s=0,c=0 hold; s=0,c=1 q<=0; s=1,c=0 q<=1; s=1,c=1 hold (never X).
  - err <= 1 if any bit has s&c, else 0.
  - err_cnt increments by 1 per conflicting command (not per bit) and saturates at 2^CNT_W-1.
- At the posedge ending cycle N, if there is no winner: gnt<=0, err<=0, q/ptr/err_cnt unchanged.
- Latency: masks are sampled in the grant cycle. q changes and gnt rises on the same edge, so the requester sees gnt and the new q together in cycle N+1.
- Handshake:
  - Requester must hold req and its masks stable until it sees gnt[i]=1.
  - It deasserts req in the gnt cycle, or keeps it high to request again. A held req becomes eligible again in cycle N+2.
  - Mask changes before grant are legal; the value sampled is the one present in the grant cycle.
- Fairness: a continuously requesting agent is granted within NREQ+1 cycles.
- Single requester holding req is granted every other cycle.
- q_bar is always derived as ~q; no independent state.

Test Plan:
- Reset mid-operation: assert rst asynchronously between edges while q=8'hA5 and gnt=4'b0010 -> q=8'h00, q_bar=8'hFF, gnt=0, err_cnt=0 without waiting for a clock edge.
- Basic set/clear: req[0] with set=8'h0F, clr=0; then req[0] with set=0, clr=8'h03 -> q=8'h0F after first grant, 8'h0C after second; gnt[0] pulses one cycle each time.
- Round-robin: req=4'b1111 held continuously, all masks 0 -> gnt sequence 0001,0010,0100,1000,0001 (one grant every cycle), ptr wraps 3->0.
- Conflict: requester 2 with set=8'h81, clr=8'h80, q=8'h00 -> q=8'h01 (bit7 held at 0), err=1 for one cycle, err_cnt=1.
- Saturation: CNT_W=2, apply 5 conflicting commands -> err_cnt sequence 1,2,3,3,3; err pulses on every one.
- Hold-off: single requester 1 holds req for 6 cycles -> gnt[1]=1 on alternate cycles only (3 grants); no other gnt bit ever set.
